// File: rtl/csr_bank.sv
// Machine-mode CSR register file: CSR read/write/set/clear, 64-bit cycle/instret
// counters, trap entry and MRET handling, and the fetch redirect target.
package csr_bank_pkg;
  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csrOperation_e;

  typedef enum logic [1:0] {
    PRIV_USER       = 2'b00,
    PRIV_SUPERVISOR = 2'b01,
    PRIV_MACHINE    = 2'b11
  } privilegeLevel_e;
endpackage

module csr_bank
  import csr_bank_pkg::*;
#(
  parameter logic [31:0] MVENDORID  = 32'h0,
  parameter logic [31:0] MIMPID     = 32'h0,
  parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            read_enable_i,
  input  logic            write_enable_i,
  input  csrOperation_e   operation_i,
  input  logic [11:0]     address_i,
  input  logic [31:0]     data_i,
  output logic [31:0]     data_o,
  output logic            illegal_o,
  input  logic            instret_i,
  input  logic            exception_i,
  input  logic [31:0]     cause_i,
  input  logic [31:0]     pc_i,
  input  logic [31:0]     tval_i,
  input  logic            mret_i,
  input  logic [2:0]      irq_i,
  output privilegeLevel_e privilege_o,
  output logic            jump_o,
  output logic [31:0]     jump_target_o,
  output logic            mie_global_o
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  privilegeLevel_e priv_q, priv_d;
  logic            status_mie_q, status_mie_d;
  logic            status_mpie_q, status_mpie_d;
  logic [1:0]      status_mpp_q, status_mpp_d;
  logic [31:0]     mie_csr_q, mie_csr_d;
  logic [31:0]     mtvec_q, mtvec_d;
  logic [31:0]     mscratch_q, mscratch_d;
  logic [31:0]     mepc_q, mepc_d;
  logic [31:0]     mcause_q, mcause_d;
  logic [31:0]     mtval_q, mtval_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic [31:0] mstatus_rd;
  logic [31:0] mip_rd;
  logic [31:0] csr_rdata;
  logic        implemented;
  logic        read_only;
  logic [31:0] csr_wdata;
  logic        write_fire;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  assign mstatus_rd = {19'd0, status_mpp_q, 3'd0, status_mpie_q, 3'd0, status_mie_q, 3'd0};
  assign mip_rd     = {20'd0, irq_i[2], 3'd0, irq_i[1], 3'd0, irq_i[0], 3'd0};

  // Address decode: selected value plus implemented/read-only classification.
  always_comb begin
    csr_rdata   = 32'd0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (address_i)
      ADDR_MSTATUS:   csr_rdata = mstatus_rd;
      ADDR_MISA:      csr_rdata = MISA_VALUE;
      ADDR_MIE:       csr_rdata = mie_csr_q;
      ADDR_MTVEC:     csr_rdata = mtvec_q;
      ADDR_MSCRATCH:  csr_rdata = mscratch_q;
      ADDR_MEPC:      csr_rdata = mepc_q;
      ADDR_MCAUSE:    csr_rdata = mcause_q;
      ADDR_MTVAL:     csr_rdata = mtval_q;
      ADDR_MIP:       begin csr_rdata = mip_rd;               read_only = 1'b1; end
      ADDR_MCYCLE:    csr_rdata = mcycle_q[31:0];
      ADDR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      ADDR_MINSTRET:  csr_rdata = minstret_q[31:0];
      ADDR_MINSTRETH: csr_rdata = minstret_q[63:32];
      ADDR_CYCLE:     begin csr_rdata = mcycle_q[31:0];       read_only = 1'b1; end
      ADDR_CYCLEH:    begin csr_rdata = mcycle_q[63:32];      read_only = 1'b1; end
      ADDR_INSTRET:   begin csr_rdata = minstret_q[31:0];     read_only = 1'b1; end
      ADDR_INSTRETH:  begin csr_rdata = minstret_q[63:32];    read_only = 1'b1; end
      ADDR_MVENDORID: begin csr_rdata = MVENDORID;            read_only = 1'b1; end
      ADDR_MARCHID:   read_only = 1'b1;
      ADDR_MIMPID:    begin csr_rdata = MIMPID;               read_only = 1'b1; end
      ADDR_MHARTID:   read_only = 1'b1;
      default:        implemented = 1'b0;
    endcase
  end

  always_comb begin
    csr_wdata = csr_rdata;
    case (operation_i)
      CSR_OP_WRITE: csr_wdata = data_i;
      CSR_OP_SET:   csr_wdata = csr_rdata | data_i;
      CSR_OP_CLEAR: csr_wdata = csr_rdata & ~data_i;
      default:      csr_wdata = csr_rdata;
    endcase
  end

  assign data_o    = read_enable_i ? csr_rdata : 32'd0;
  assign illegal_o = (read_enable_i && !implemented) ||
                     (write_enable_i && (!implemented || read_only));
  // Traps and MRET own the cycle; a coinciding CSR write is dropped.
  assign write_fire = write_enable_i && implemented && !read_only &&
                      (operation_i != CSR_OP_NONE) && !exception_i && !mret_i;

  assign trap_base   = {mtvec_q[31:2], 2'b00};
  assign trap_target = ((mtvec_q[1:0] == 2'b01) && cause_i[31]) ?
                       trap_base + {25'd0, cause_i[4:0], 2'b00} : trap_base;

  assign jump_o        = exception_i || mret_i;
  assign jump_target_o = exception_i ? trap_target : (mret_i ? mepc_q : 32'd0);
  assign privilege_o   = priv_q;
  assign mie_global_o  = status_mie_q;

  always_comb begin
    priv_d        = priv_q;
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    status_mpp_d  = status_mpp_q;
    mie_csr_d     = mie_csr_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    mcycle_d      = mcycle_q + 64'd1;
    minstret_d    = instret_i ? minstret_q + 64'd1 : minstret_q;

    if (exception_i) begin
      mepc_d        = pc_i;
      mcause_d      = cause_i;
      mtval_d       = tval_i;
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
      status_mpp_d  = priv_q;
      priv_d        = PRIV_MACHINE;
    end else if (mret_i) begin
      status_mie_d  = status_mpie_q;
      status_mpie_d = 1'b1;
      priv_d        = privilegeLevel_e'(status_mpp_q);
      status_mpp_d  = PRIV_USER;
    end else if (write_fire) begin
      // A counter-half write replaces that cycle's increment; the other half holds.
      case (address_i)
        ADDR_MSTATUS: begin
          status_mie_d  = csr_wdata[3];
          status_mpie_d = csr_wdata[7];
          status_mpp_d  = csr_wdata[12:11];
        end
        ADDR_MIE:       mie_csr_d  = csr_wdata;
        ADDR_MTVEC:     mtvec_d    = csr_wdata;
        ADDR_MSCRATCH:  mscratch_d = csr_wdata;
        ADDR_MEPC:      mepc_d     = {csr_wdata[31:2], 2'b00};
        ADDR_MCAUSE:    mcause_d   = csr_wdata;
        ADDR_MTVAL:     mtval_d    = csr_wdata;
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_wdata};
        ADDR_MCYCLEH:   mcycle_d   = {csr_wdata, mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_wdata};
        ADDR_MINSTRETH: minstret_d = {csr_wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      priv_q        <= PRIV_MACHINE;
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      status_mpp_q  <= 2'b00;
      mie_csr_q     <= 32'd0;
      mtvec_q       <= 32'd0;
      mscratch_q    <= 32'd0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      mtval_q       <= 32'd0;
      mcycle_q      <= 64'd0;
      minstret_q    <= 64'd0;
    end else begin
      priv_q        <= priv_d;
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      status_mpp_q  <= status_mpp_d;
      mie_csr_q     <= mie_csr_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank: CSR access ops, counters, trap/MRET sequencing,
// illegal accesses and asynchronous reset, with hand-computed expectations.
module tb_csr_bank;
  import csr_bank_pkg::*;

  logic            clk;
  logic            reset;
  logic            read_enable_i;
  logic            write_enable_i;
  csrOperation_e   operation_i;
  logic [11:0]     address_i;
  logic [31:0]     data_i;
  logic [31:0]     data_o;
  logic            illegal_o;
  logic            instret_i;
  logic            exception_i;
  logic [31:0]     cause_i;
  logic [31:0]     pc_i;
  logic [31:0]     tval_i;
  logic            mret_i;
  logic [2:0]      irq_i;
  privilegeLevel_e privilege_o;
  logic            jump_o;
  logic [31:0]     jump_target_o;
  logic            mie_global_o;

  int n_cmp = 0;
  int n_err = 0;

  csr_bank dut (
    .clk            (clk),
    .reset          (reset),
    .read_enable_i  (read_enable_i),
    .write_enable_i (write_enable_i),
    .operation_i    (operation_i),
    .address_i      (address_i),
    .data_i         (data_i),
    .data_o         (data_o),
    .illegal_o      (illegal_o),
    .instret_i      (instret_i),
    .exception_i    (exception_i),
    .cause_i        (cause_i),
    .pc_i           (pc_i),
    .tval_i         (tval_i),
    .mret_i         (mret_i),
    .irq_i          (irq_i),
    .privilege_o    (privilege_o),
    .jump_o         (jump_o),
    .jump_target_o  (jump_target_o),
    .mie_global_o   (mie_global_o)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    read_enable_i  = 1'b0;
    write_enable_i = 1'b0;
    operation_i    = CSR_OP_NONE;
    address_i      = 12'h000;
    data_i         = 32'd0;
    exception_i    = 1'b0;
    mret_i         = 1'b0;
    cause_i        = 32'd0;
    pc_i           = 32'd0;
    tval_i         = 32'd0;
  endtask

  // One request cycle: drive after the edge, check mid-cycle, advance one edge.
  task automatic access(input string tag, input logic re, input logic we,
                        input csrOperation_e op, input logic [11:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_data,
                        input logic exp_ill);
    read_enable_i  = re;
    write_enable_i = we;
    operation_i    = op;
    address_i      = addr;
    data_i         = data;
    @(negedge clk);
    check({tag, ".data"}, data_o, exp_data);
    check({tag, ".ill"}, {31'd0, illegal_o}, {31'd0, exp_ill});
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    access(tag, 1'b1, 1'b0, CSR_OP_NONE, addr, 32'd0, exp, 1'b0);
  endtask

  task automatic wr(input string tag, input logic [11:0] addr, input csrOperation_e op,
                    input logic [31:0] data, input logic exp_ill);
    access(tag, 1'b0, 1'b1, op, addr, data, 32'd0, exp_ill);
  endtask

  task automatic trap_event(input string tag, input logic exc, input logic mret,
                            input logic [31:0] cause, input logic [31:0] pc,
                            input logic [31:0] tval, input logic [31:0] exp_target);
    exception_i = exc;
    mret_i      = mret;
    cause_i     = cause;
    pc_i        = pc;
    tval_i      = tval;
    @(negedge clk);
    check({tag, ".jump"}, {31'd0, jump_o}, 32'd1);
    check({tag, ".target"}, jump_target_o, exp_target);
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    drive_idle();
    instret_i = 1'b0;
    irq_i     = 3'b000;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.priv", 32'(privilege_o), 32'(PRIV_MACHINE));
    check("rst.jump", {31'd0, jump_o}, 32'd0);
    check("rst.mie", {31'd0, mie_global_o}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    rd("rst.mstatus", 12'h300, 32'h0);
    rd("rst.mvendorid", 12'hF11, 32'h0);
    rd("misa", 12'h301, 32'h40000100);
    rd("mhartid", 12'hF14, 32'h0);
    wr("misa.wr", 12'h301, CSR_OP_WRITE, 32'hFFFFFFFF, 1'b0);
    rd("misa.after", 12'h301, 32'h40000100);

    wr("mscratch.write", 12'h340, CSR_OP_WRITE, 32'hA5A5A5A5, 1'b0);
    rd("mscratch.r1", 12'h340, 32'hA5A5A5A5);
    wr("mscratch.set", 12'h340, CSR_OP_SET, 32'h0000000F, 1'b0);
    rd("mscratch.r2", 12'h340, 32'hA5A5A5AF);
    // Read and CLEAR in the same cycle: the read sees the pre-edge value.
    access("mscratch.clr", 1'b1, 1'b1, CSR_OP_CLEAR, 12'h340, 32'hA0000000, 32'hA5A5A5AF, 1'b0);
    rd("mscratch.r3", 12'h340, 32'h05A5A5AF);
    wr("mstatus.mask", 12'h300, CSR_OP_WRITE, 32'hFFFFFFFF, 1'b0);
    rd("mstatus.mask", 12'h300, 32'h00001888);
    wr("mstatus.clr", 12'h300, CSR_OP_CLEAR, 32'hFFFFFFFF, 1'b0);

    // mcycle carry: FFFFFFFE -> FFFFFFFF -> {1,0} -> {1,1} over three idle edges
    wr("mcycle.wr", 12'hB00, CSR_OP_WRITE, 32'hFFFFFFFE, 1'b0);
    wr("mcycleh.wr", 12'hB80, CSR_OP_WRITE, 32'h0, 1'b0);
    idle_cycles(3);
    rd("mcycle.carry", 12'hB00, 32'h00000001);
    rd("mcycleh.carry", 12'hB80, 32'h00000001);
    wr("mcycle.wr2", 12'hB00, CSR_OP_WRITE, 32'h00000100, 1'b0);
    rd("mcycle.wins", 12'hB00, 32'h00000100);
    wr("cycle.ro", 12'hC00, CSR_OP_WRITE, 32'h00005555, 1'b1);
    rd_unimpl();
    rd("cycle.shadow", 12'hC00, 32'h00000103);
    rd("cycleh.shadow", 12'hC80, 32'h00000001);
    wr("mip.ro", 12'h344, CSR_OP_WRITE, 32'hFFFFFFFF, 1'b1);
    wr("unimpl.wr", 12'h7C0, CSR_OP_WRITE, 32'hFFFFFFFF, 1'b1);
    wr("mvendorid.ro", 12'hF11, CSR_OP_SET, 32'h1, 1'b1);

    instret_i = 1'b1;
    wr("minstret.wr", 12'hB02, CSR_OP_WRITE, 32'hFFFFFFFF, 1'b0);
    idle_cycles(1);
    instret_i = 1'b0;
    rd("minstret.lo", 12'hB02, 32'h00000000);
    rd("minstret.hi", 12'hB82, 32'h00000001);
    rd("instreth.shadow", 12'hC82, 32'h00000001);

    irq_i = 3'b101;
    rd("mip.101", 12'h344, 32'h00000808);
    irq_i = 3'b010;
    rd("mip.010", 12'h344, 32'h00000080);
    irq_i = 3'b000;
    wr("mepc.wr", 12'h341, CSR_OP_WRITE, 32'h00001003, 1'b0);
    rd("mepc.align", 12'h341, 32'h00001000);
    wr("mie.wr", 12'h304, CSR_OP_WRITE, 32'h00000888, 1'b0);
    rd("mie.rd", 12'h304, 32'h00000888);

    // Drop to user mode with MIE=1 via MRET; a coinciding mscratch write is dropped.
    wr("mtvec.wr", 12'h305, CSR_OP_WRITE, 32'h80000001, 1'b0);
    wr("mstatus.mpie", 12'h300, CSR_OP_WRITE, 32'h00000080, 1'b0);
    write_enable_i = 1'b1;
    operation_i    = CSR_OP_WRITE;
    address_i      = 12'h340;
    data_i         = 32'hDEADBEEF;
    trap_event("mret0", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h00001000);
    check("mret0.priv", 32'(privilege_o), 32'(PRIV_USER));
    check("mret0.mie", {31'd0, mie_global_o}, 32'd1);
    rd("mret0.drop", 12'h340, 32'h05A5A5AF);

    trap_event("irq7", 1'b1, 1'b0, 32'h80000007, 32'h00001234, 32'h00000055, 32'h8000001C);
    check("irq7.priv", 32'(privilege_o), 32'(PRIV_MACHINE));
    check("irq7.mie", {31'd0, mie_global_o}, 32'd0);
    rd("irq7.mepc", 12'h341, 32'h00001234);
    rd("irq7.mcause", 12'h342, 32'h80000007);
    rd("irq7.mtval", 12'h343, 32'h00000055);
    rd("irq7.mstatus", 12'h300, 32'h00000080);

    trap_event("mret1", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h00001234);
    check("mret1.priv", 32'(privilege_o), 32'(PRIV_USER));
    check("mret1.mie", {31'd0, mie_global_o}, 32'd1);
    rd("mret1.mstatus", 12'h300, 32'h00000088);

    trap_event("both", 1'b1, 1'b1, 32'h00000002, 32'h00002000, 32'h0, 32'h80000000);
    check("both.priv", 32'(privilege_o), 32'(PRIV_MACHINE));
    rd("both.mstatus", 12'h300, 32'h00000080);
    rd("both.mepc", 12'h341, 32'h00002000);

    wr("mtvec.direct", 12'h305, CSR_OP_WRITE, 32'h80000100, 1'b0);
    trap_event("direct", 1'b1, 1'b0, 32'h8000000B, 32'h00003000, 32'h0, 32'h80000100);
    @(negedge clk);
    check("idle.jump", {31'd0, jump_o}, 32'd0);
    check("idle.target", jump_target_o, 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    reset         = 1'b1;
    read_enable_i = 1'b1;
    address_i     = 12'h340;
    #1;
    check("arst.mscratch", data_o, 32'h0);
    check("arst.priv", 32'(privilege_o), 32'(PRIV_MACHINE));
    address_i = 12'h305;
    #1;
    check("arst.mtvec", data_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    rd("post.mepc", 12'h341, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic rd_unimpl();
    access("unimpl.rd", 1'b1, 1'b0, CSR_OP_NONE, 12'h7C0, 32'h0, 32'h0, 1'b1);
  endtask

endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
- Machine-mode CSR register file: the responder for CSR access requests from the execute-stage CSR request unit.
- Services read/write/set/clear accesses and keeps the 64-bit cycle and instret counters.
- Handles trap entry (exception/interrupt) and MRET return; tracks the current privilege level.
- Supplies the trap/return target PC to the fetch stage.

Parameters:
- MVENDORID, 32'h0, value returned for 0xF11
- MIMPID, 32'h0, value returned for 0xF13
- MISA_VALUE, 32'h40000100, value returned for 0x301 (RV32I); writes ignored

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- read_enable_i  in  1  CSR read request
- write_enable_i  in  1  CSR write request
- operation_i  in  csrOperation_e  WRITE / SET / CLEAR / NONE
- address_i  in  12  CSR address
- data_i  in  32  write operand
- data_o  out  32  read data
- illegal_o  out  1  access to unimplemented CSR, or write to a read-only CSR
- instret_i  in  1  one instruction retired this cycle
- exception_i  in  1  take trap this cycle
- cause_i  in  32  mcause value; bit31 = interrupt
- pc_i  in  32  PC of trapping instruction
- tval_i  in  32  mtval value
- mret_i  in  1  MRET executed
- irq_i  in  3  pending MEI/MTI/MSI, mirrored into mip bits 11/7/3
- privilege_o  out  privilegeLevel_e  current privilege level
- jump_o  out  1  redirect fetch this cycle
- jump_target_o  out  32  redirect PC
- mie_global_o  out  1  mstatus.MIE

Behaviour:
- Reset (async, reset=1): all CSRs 0; privilege_o=MACHINE; jump_o=0.
- Implemented CSRs:
  - mstatus 0x300: only MIE(3), MPIE(7), MPP(12:11) writable; all other bits read 0.
  - misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - mip 0x344: read-only view of irq_i.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - User shadows cycle/cycleh/instret/instreth at 0xC00/0xC80/0xC02/0xC82: read-only.
  - mvendorid/marchid/mimpid/mhartid 0xF11–0xF14: read-only.
- Reads:
  - Combinational: data_o = selected CSR when read_enable_i, else 0.
  - Unimplemented address: data_o=0, illegal_o=1.
- Writes:
  - Take effect on the next rising edge; a read in the same cycle returns the old value.
  - new value: WRITE=data_i; SET=old|data_i; CLEAR=old&~data_i; NONE=no change.
  - mepc bits[1:0] are forced to 0.
  - illegal_o=1 when write_enable_i targets a read-only or unimplemented CSR; no state change.
  - illegal_o is combinational and 0 when no request is present.
- Counters:
  - mcycle (64-bit) increments every cycle.
  - minstret (64-bit) increments when instret_i=1.
  - Low-word carry propagates into the high word on the same edge (0xFFFFFFFF → low 0, high+1).
  - A CSR write to any counter half replaces the increment for that cycle: the written half takes the new value, and the other half holds.
- Trap entry (exception_i=1), on the edge:
  - mepc←pc_i, mcause←cause_i, mtval←tval_i.
  - MPIE←MIE, MIE←0, MPP←privilege, privilege←MACHINE.
  - Same cycle, combinational: jump_o=1 and jump_target_o as follows:
    - mtvec[1:0]=01 and cause_i[31]=1: {mtvec[31:2],2'b00}+4*cause_i[4:0].
    - Otherwise: {mtvec[31:2],2'b00}.
- MRET (mret_i=1, exception_i=0), on the edge:
  - MIE←MPIE, MPIE←1, privilege←MPP, MPP←USER.
  - jump_o=1, jump_target_o=mepc (value before the edge).
- Priority: exception_i > mret_i > CSR write.
  - A CSR write coinciding with a trap or MRET is dropped.
  - Counter increments still occur in that cycle.
- jump_target_o=0 when jump_o=0.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
- Reset, then read 0x300 and 0xF11 → data_o=0, illegal_o=0; privilege_o=MACHINE.
- WRITE 0x340←0xA5A5A5A5, SET 0x340 with 0x0000000F, CLEAR 0x340 with 0xA0000000 → successive reads 0xA5A5A5A5, 0xA5A5A5AF, 0x05A5A5AF.
- Write 0xC00, then read unimplemented 0x7C0 → illegal_o=1 both times; no state change; data_o=0 for 0x7C0.
- WRITE mcycle←0xFFFFFFFE, mcycleh←0; idle 3 cycles → mcycle=0x00000001, mcycleh=1; write mcycle concurrent with increment → written value wins.
- mtvec=0x80000001, MIE=1, privilege USER; exception_i with cause 0x80000007, pc 0x1234 → jump_target_o=0x8000001C; mepc=0x1234; MIE=0, MPIE=1, MPP=USER, privilege=MACHINE.
- Then mret_i → jump_target_o=0x1234, MIE=1, privilege=USER, MPP=USER; mret_i together with exception_i → trap taken, MRET ignored.
